ysyx_24100005_core_ctrl: RTL and testbench
==========================================

Name: ysyx_24100005_core_ctrl

Overview:
Multi-cycle sequencer for the ysyx_24100005 core.
- Owns the PC and runs the instruction-memory fetch handshake.
- Latches the fetched instruction for the combinational decode/execute datapath.
- Issues one-cycle commit strobes: register-file write enable and PC update.
- Detects EBREAK (halt), fetch timeout and misaligned next-PC (error).

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
FETCH_TIMEOUT, 16, max cycles in WAIT without a response before error (1..255)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address (= pc)
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  32  fetched instruction
inst  out  32  latched instruction, driven to datapath
pc  out  32  current PC
next_pc  in  32  next PC computed by datapath from inst/pc
rf_wen  out  1  register-file write strobe
ebreak  out  1  one-cycle pulse on EBREAK retire
halt  out  1  core stopped by EBREAK
err  out  1  core stopped by error

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (NOP).
  - All strobes 0, halt=0, err=0, timeout counter=0.
- Reset asserted mid-transaction: in-flight request is abandoned; a later stray imem_rsp_valid is ignored (only sampled in WAIT).
- States:
  - IDLE: 1 cycle after reset release -> FETCH.
  - FETCH: imem_req_valid=1, imem_req_addr=pc. On imem_req_valid & imem_req_ready -> WAIT, counter=0. Valid holds until accepted; addr stable while valid.
  - WAIT: on imem_rsp_valid, inst<=imem_rsp_data -> EXEC. Otherwise counter++. When counter reaches FETCH_TIMEOUT-1 with no response -> ERR. A response on that same cycle wins.
  - EXEC: 1 settle cycle for the combinational datapath; no strobes.
    - inst==32'h0010_0073 (EBREAK) -> HALT.
    - Else if next_pc[1:0]!=0 -> ERR.
    - Else -> WB.
  - WB: pc<=next_pc at end of cycle. rf_wen=1 for one cycle iff inst[6:0] is one of 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111 (asserted even when rd=0; regfile ignores x0). -> FETCH.
  - HALT: ebreak=1 on the entry cycle only; halt=1 sticky; pc holds the EBREAK address. Exit only by reset.
  - ERR: err=1 sticky; pc unchanged; no requests issued. Exit only by reset.
- imem_rsp_valid is ignored outside WAIT. A response in the same cycle as request acceptance is not captured; memory latency is >=1 cycle.
- Minimum CPI = 4 (FETCH, WAIT, EXEC, WB) with ready=1 and 1-cycle response latency.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC -> 32'h0000_0000 is legal wrap.
- rf_wen, ebreak and imem_req_valid are registered-state decodes: glitch-free, one-hot with state.

Optional Feature:
Macro: YSYX_24100005_PERF_CNT_EN
- Defined:
  - Adds outputs perf_cycle[63:0] and perf_instret[63:0], both reset to 0.
  - perf_cycle increments every cycle the state is not HALT/ERR.
  - perf_instret increments on each WB cycle and on HALT entry.
  - Counters wrap at 2^64.
- Undefined: the ports do not exist and no counter logic is built.

Test Plan:
- Reset release, ready=1, 1-cycle latency, inst=32'h0010_0093 (addi x1,x0,1), next_pc=pc+4 -> req addr 8000_0000; rf_wen pulses in cycle 4 after IDLE; pc becomes 8000_0004; next req addr 8000_0004.
- imem_req_ready low for 3 cycles -> imem_req_valid held 4 cycles with addr constant; single transfer; no duplicate fetch.
- Fetch inst=32'h0010_0073 -> ebreak pulses 1 cycle, halt=1, pc stays 8000_0000, no further imem_req_valid for 20 cycles.
- No response in WAIT with FETCH_TIMEOUT=16 -> err=1 after 16 WAIT cycles. Response arriving on the 16th cycle -> no err, enters EXEC.
- next_pc=32'h8000_0006 from datapath -> err=1, rf_wen never asserted, pc stays 8000_0000.
- rst driven low mid-WAIT, then a stray imem_rsp_valid arrives -> pc=8000_0000, inst=0000_0013, all strobes 0. After release, fetch restarts at 8000_0000. With PERF_CNT_EN, both counters read 0 at release.

Source files
------------

// File: rtl/ysyx_24100005_core_ctrl_if.sv
// Instruction-memory fetch bus for the ysyx_24100005 core sequencer.
// master = core side (issues requests, consumes responses),
// slave  = memory side.
interface ysyx_24100005_core_ctrl_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/ysyx_24100005_core_ctrl.sv
// Multi-cycle sequencer for the ysyx_24100005 core.
// Owns the PC, runs the instruction fetch handshake, latches the fetched
// instruction for the combinational datapath and issues one-cycle commit
// strobes. Stops on EBREAK (halt), fetch timeout or misaligned next PC (err).
// Optional cycle / retired-instruction counters are built when
// YSYX_24100005_PERF_CNT_EN is defined.
module ysyx_24100005_core_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  ysyx_24100005_core_ctrl_if.master        imem,
  output logic [31:0]                      inst,
  output logic [31:0]                      pc,
  input  logic [31:0]                      next_pc,
  output logic                             rf_wen,
  output logic                             ebreak,
  output logic                             halt,
  output logic                             err
`ifdef YSYX_24100005_PERF_CNT_EN
  ,
  output logic [63:0]                      perf_cycle,
  output logic [63:0]                      perf_instret
`endif
);

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [7:0]  TO_LAST     = 8'(FETCH_TIMEOUT - 1);

  // S_BRK is the single HALT entry cycle (carries the ebreak pulse);
  // S_HALT is the sticky stopped state that follows it.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_WB,
    S_BRK,
    S_HALT,
    S_ERR
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;

  // Opcodes whose instructions write rd (x0 writes are dropped by the regfile).
  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: writes_rd = 1'b1;
      default:                            writes_rd = 1'b0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a response in the last WAIT cycle beats the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (imem.imem_req_ready) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem.imem_rsp_valid)     state_nxt = S_EXEC;
        else if (wait_cnt == TO_LAST) state_nxt = S_ERR;
      end
      S_EXEC: begin
        if (inst == EBREAK_INST)     state_nxt = S_BRK;
        else if (next_pc[1:0] != 2'b00) state_nxt = S_ERR;
        else                         state_nxt = S_WB;
      end
      S_WB:    state_nxt = S_FETCH;
      S_BRK:   state_nxt = S_HALT;
      S_HALT:  state_nxt = S_HALT;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Output decode straight from the state register so strobes are glitch-free.
  always_comb begin
    imem.imem_req_valid = (state == S_FETCH);
    imem.imem_req_addr  = pc;
    rf_wen              = (state == S_WB) && writes_rd(inst[6:0]);
    ebreak              = (state == S_BRK);
    halt                = (state == S_BRK) || (state == S_HALT);
    err                 = (state == S_ERR);
  end

  // WAIT-cycle counter: counts consecutive WAIT cycles without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          wait_cnt <= 8'd0;
    else if ((state == S_WAIT) && !imem.imem_rsp_valid) wait_cnt <= wait_cnt + 8'd1;
    else                                               wait_cnt <= 8'd0;
  end

  // Instruction latch; responses are only honoured in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         inst <= NOP_INST;
    else if ((state == S_WAIT) && imem.imem_rsp_valid) inst <= imem.imem_rsp_data;
  end

  // PC commit at the end of WB (32-bit modulo, wrap is legal).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                pc <= RESET_PC;
    else if (state == S_WB)  pc <= next_pc;
  end

`ifdef YSYX_24100005_PERF_CNT_EN
  // Performance counters: cycles while running, retirements on WB and EBREAK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycle   <= 64'd0;
      perf_instret <= 64'd0;
    end else begin
      if ((state != S_BRK) && (state != S_HALT) && (state != S_ERR))
        perf_cycle <= perf_cycle + 64'd1;
      if ((state == S_WB) || (state == S_BRK))
        perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24100005_core_ctrl.sv
// Self-checking bench for ysyx_24100005_core_ctrl: directed scenarios plus a
// randomized instruction stream checked against a PC / rf_wen model.
`timescale 1ns/1ps
module tb_ysyx_24100005_core_ctrl;
  localparam logic [31:0] RESET_PC      = 32'h8000_0000;
  localparam int          FETCH_TIMEOUT = 16;
  localparam logic [31:0] EBREAK_I      = 32'h0010_0073;
  localparam logic [31:0] ADDI_I        = 32'h0010_0093;
  localparam logic [31:0] NOP_I         = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        rf_wen;
  logic        ebreak;
  logic        halt;
  logic        err;
  logic        np_force;
  logic [31:0] np_val;
`ifdef YSYX_24100005_PERF_CNT_EN
  logic [63:0] perf_cycle;
  logic [63:0] perf_instret;
`endif

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int hs_cnt = 0;

  ysyx_24100005_core_ctrl_if imem_bus ();

  ysyx_24100005_core_ctrl #(
    .RESET_PC      (RESET_PC),
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem_bus),
    .inst         (inst),
    .pc           (pc),
    .next_pc      (next_pc),
    .rf_wen       (rf_wen),
    .ebreak       (ebreak),
    .halt         (halt),
    .err          (err)
`ifdef YSYX_24100005_PERF_CNT_EN
    ,
    .perf_cycle   (perf_cycle),
    .perf_instret (perf_instret)
`endif
  );

  always #5 clk = ~clk;

  // Datapath stand-in: sequential next PC unless a test forces a value.
  assign next_pc = np_force ? np_val : pc + 32'd4;

  always @(posedge clk)
    if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) hs_cnt <= hs_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    imem_bus.imem_req_ready = 1'b0;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = 32'hDEAD_BEEF;
    np_force = 1'b0;
    np_val   = 32'h0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // Memory responder: stall ready for rdy_dly cycles, respond after lat cycles.
  // Returns with the DUT in EXEC, sampled 1 ns after the edge.
  task automatic serve_fetch(input logic [31:0] data, input int rdy_dly, input int lat,
                             output logic [31:0] addr, output int req_cycles,
                             output bit addr_bad, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    addr_bad = 1'b0;
    req_cycles = 0;
    addr = 32'h0;
    while (!imem_bus.imem_req_valid && n < 50) begin
      tick();
      n++;
    end
    if (!imem_bus.imem_req_valid) begin
      timed_out = 1'b1;
      return;
    end
    addr = imem_bus.imem_req_addr;
    for (int i = 0; i <= rdy_dly; i++) begin
      imem_bus.imem_req_ready = (i == rdy_dly);
      if (!imem_bus.imem_req_valid || imem_bus.imem_req_addr !== addr) addr_bad = 1'b1;
      req_cycles++;
      tick();
    end
    imem_bus.imem_req_ready = 1'b0;
    repeat (lat - 1) tick();
    imem_bus.imem_rsp_valid = 1'b1;
    imem_bus.imem_rsp_data  = data;
    tick();
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = $urandom;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (pc !== RESET_PC) $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); else passes++;
    checks++; if (inst !== NOP_I) $display("FAIL reset_inst got=%h exp=%h", inst, NOP_I); else passes++;
    checks++;
    if ({imem_bus.imem_req_valid, rf_wen, ebreak, halt, err} !== 5'b0)
      $display("FAIL reset_strobes got=%b exp=00000", {imem_bus.imem_req_valid, rf_wen, ebreak, halt, err});
    else passes++;
`ifdef YSYX_24100005_PERF_CNT_EN
    checks++;
    if (perf_cycle !== 64'd0 || perf_instret !== 64'd0)
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_cycle, perf_instret);
    else passes++;
`endif
    tick();
    checks++;
    if (imem_bus.imem_req_valid !== 1'b1 || imem_bus.imem_req_addr !== RESET_PC)
      $display("FAIL first_req got=%b/%h exp=1/%h", imem_bus.imem_req_valid, imem_bus.imem_req_addr, RESET_PC);
    else passes++;
  endtask

  task automatic test_basic();
    logic [31:0] a; int rc; bit bad, to;
    apply_reset();
    serve_fetch(ADDI_I, 0, 1, a, rc, bad, to);
    checks++; if (to || a !== RESET_PC) $display("FAIL basic_addr got=%h to=%b exp=%h", a, to, RESET_PC); else passes++;
    checks++; if (rf_wen !== 1'b0 || inst !== ADDI_I) $display("FAIL basic_exec got=%b/%h exp=0/%h", rf_wen, inst, ADDI_I); else passes++;
    tick();
    checks++; if (rf_wen !== 1'b1 || pc !== RESET_PC) $display("FAIL basic_wb got=%b/%h exp=1/%h", rf_wen, pc, RESET_PC); else passes++;
    tick();
    checks++;
    if (rf_wen !== 1'b0 || pc !== 32'h8000_0004 || imem_bus.imem_req_valid !== 1'b1 || imem_bus.imem_req_addr !== 32'h8000_0004)
      $display("FAIL basic_next got=%b/%h/%b/%h exp=0/80000004/1/80000004", rf_wen, pc, imem_bus.imem_req_valid, imem_bus.imem_req_addr);
    else passes++;
  endtask

  task automatic test_ready_stall();
    logic [31:0] a; int rc; bit bad, to; int hs0;
    apply_reset();
    hs0 = hs_cnt;
    serve_fetch(ADDI_I, 3, 1, a, rc, bad, to);
    checks++; if (to || rc != 4 || bad) $display("FAIL stall_hold got=%0d bad=%b to=%b exp=4 bad=0", rc, bad, to); else passes++;
    repeat (2) tick();
    checks++; if (hs_cnt - hs0 != 1) $display("FAIL stall_single got=%0d exp=1", hs_cnt - hs0); else passes++;
    checks++; if (imem_bus.imem_req_addr !== 32'h8000_0004) $display("FAIL stall_next got=%h exp=80000004", imem_bus.imem_req_addr); else passes++;
  endtask

  task automatic test_ebreak();
    logic [31:0] a; int rc; bit bad, to; int vcnt, ecnt;
    apply_reset();
    serve_fetch(EBREAK_I, 0, 1, a, rc, bad, to);
    checks++; if (to || ebreak !== 1'b0 || halt !== 1'b0) $display("FAIL ebrk_exec got=%b/%b exp=0/0", ebreak, halt); else passes++;
    tick();
    checks++; if (ebreak !== 1'b1 || halt !== 1'b1 || pc !== RESET_PC) $display("FAIL ebrk_entry got=%b/%b/%h exp=1/1/%h", ebreak, halt, pc, RESET_PC); else passes++;
    vcnt = 0; ecnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_bus.imem_req_valid) vcnt++;
      if (ebreak) ecnt++;
    end
    checks++; if (vcnt != 0 || ecnt != 0 || halt !== 1'b1 || rf_wen !== 1'b0) $display("FAIL ebrk_after got=req%0d/ebrk%0d/halt%b exp=0/0/1", vcnt, ecnt, halt); else passes++;
  endtask

  task automatic test_timeout();
    int n, cnt, vcnt;
    apply_reset();
    n = 0;
    while (!imem_bus.imem_req_valid && n < 50) begin tick(); n++; end
    imem_bus.imem_req_ready = 1'b1;
    tick();
    imem_bus.imem_req_ready = 1'b0;
    cnt = 0;
    while (!err && cnt < 40) begin tick(); cnt++; end
    checks++; if (cnt != FETCH_TIMEOUT) $display("FAIL timeout_len got=%0d exp=%0d", cnt, FETCH_TIMEOUT); else passes++;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (imem_bus.imem_req_valid) vcnt++; end
    checks++; if (err !== 1'b1 || vcnt != 0 || pc !== RESET_PC) $display("FAIL timeout_sticky got=%b/%0d/%h exp=1/0/%h", err, vcnt, pc, RESET_PC); else passes++;
  endtask

  task automatic test_timeout_edge();
    int n;
    apply_reset();
    n = 0;
    while (!imem_bus.imem_req_valid && n < 50) begin tick(); n++; end
    imem_bus.imem_req_ready = 1'b1;
    tick();
    imem_bus.imem_req_ready = 1'b0;
    repeat (FETCH_TIMEOUT - 1) tick();
    checks++; if (err !== 1'b0) $display("FAIL edge_pre got=%b exp=0", err); else passes++;
    imem_bus.imem_rsp_valid = 1'b1;
    imem_bus.imem_rsp_data  = ADDI_I;
    tick();
    imem_bus.imem_rsp_valid = 1'b0;
    checks++; if (err !== 1'b0 || inst !== ADDI_I) $display("FAIL edge_exec got=%b/%h exp=0/%h", err, inst, ADDI_I); else passes++;
    tick();
    checks++; if (rf_wen !== 1'b1) $display("FAIL edge_wb got=%b exp=1", rf_wen); else passes++;
  endtask

  task automatic test_misaligned();
    logic [31:0] a; int rc; bit bad, to; int wcnt, vcnt;
    apply_reset();
    np_force = 1'b1;
    np_val   = 32'h8000_0006;
    serve_fetch(ADDI_I, 0, 1, a, rc, bad, to);
    tick();
    checks++; if (to || err !== 1'b1) $display("FAIL mis_err got=%b exp=1", err); else passes++;
    wcnt = 0; vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rf_wen) wcnt++;
      if (imem_bus.imem_req_valid) vcnt++;
    end
    checks++; if (wcnt != 0 || vcnt != 0 || pc !== RESET_PC) $display("FAIL mis_after got=wen%0d/req%0d/%h exp=0/0/%h", wcnt, vcnt, pc, RESET_PC); else passes++;
    np_force = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a; int rc; bit bad, to; int n;
    apply_reset();
    np_force = 1'b1;
    np_val   = 32'h8000_0100;
    serve_fetch(ADDI_I, 0, 1, a, rc, bad, to);
    repeat (2) tick();
    np_force = 1'b0;
    checks++; if (pc !== 32'h8000_0100) $display("FAIL mid_pre_pc got=%h exp=80000100", pc); else passes++;
    n = 0;
    while (!imem_bus.imem_req_valid && n < 50) begin tick(); n++; end
    imem_bus.imem_req_ready = 1'b1;
    tick();
    imem_bus.imem_req_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (pc !== RESET_PC || inst !== NOP_I || {imem_bus.imem_req_valid, rf_wen, ebreak, halt, err} !== 5'b0)
      $display("FAIL mid_async got=%h/%h/%b exp=%h/%h/00000", pc, inst,
               {imem_bus.imem_req_valid, rf_wen, ebreak, halt, err}, RESET_PC, NOP_I);
    else passes++;
    imem_bus.imem_rsp_valid = 1'b1;
    imem_bus.imem_rsp_data  = EBREAK_I;
    tick();
    checks++; if (inst !== NOP_I || pc !== RESET_PC) $display("FAIL mid_stray_rst got=%h/%h exp=%h/%h", inst, pc, NOP_I, RESET_PC); else passes++;
`ifdef YSYX_24100005_PERF_CNT_EN
    checks++;
    if (perf_cycle !== 64'd0 || perf_instret !== 64'd0)
      $display("FAIL mid_perf got=%0d/%0d exp=0/0", perf_cycle, perf_instret);
    else passes++;
`endif
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (inst !== NOP_I || imem_bus.imem_req_valid !== 1'b1 || imem_bus.imem_req_addr !== RESET_PC)
      $display("FAIL mid_stray_run got=%h/%b/%h exp=%h/1/%h", inst, imem_bus.imem_req_valid, imem_bus.imem_req_addr, NOP_I, RESET_PC);
    else passes++;
    imem_bus.imem_rsp_valid = 1'b0;
    serve_fetch(ADDI_I, 0, 1, a, rc, bad, to);
    checks++; if (to || a !== RESET_PC || inst !== ADDI_I) $display("FAIL mid_restart got=%h/%h exp=%h/%h", a, inst, RESET_PC, ADDI_I); else passes++;
  endtask

  task automatic test_random();
    logic [6:0]  opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67,
                              7'h23, 7'h63, 7'h73, 7'h0F};
    logic [6:0]  wr_opcs [7] = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
    logic [31:0] exp_pc, exp_npc, data, a;
    int rc, cyc0, errs;
    bit bad, to, exp_wen;
    apply_reset();
    cyc0 = cyc;
    exp_pc = RESET_PC;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      data = {$urandom} & 32'hFFFF_FF80;
      data[6:0] = opcs[$urandom_range(0, 10)];
      if (data == EBREAK_I) data ^= 32'h8000_0000;
      exp_wen = 1'b0;
      foreach (wr_opcs[k]) if (data[6:0] == wr_opcs[k]) exp_wen = 1'b1;
      if (i == 5) begin
        np_force = 1'b1; np_val = 32'hFFFF_FFFC;
      end else if (i != 6 && $urandom_range(0, 2) == 0) begin
        np_force = 1'b1; np_val = {$urandom} & 32'hFFFF_FFFC;
      end else begin
        np_force = 1'b0;
      end
      exp_npc = np_force ? np_val : exp_pc + 32'd4;
      serve_fetch(data, $urandom_range(0, 3), $urandom_range(1, 5), a, rc, bad, to);
      if (to) begin
        checks++; $display("FAIL rnd_timeout i=%0d got=no_request exp=request", i);
        break;
      end
      checks++; if (a !== exp_pc || bad) begin $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, a, exp_pc); errs++; end else passes++;
      checks++; if (inst !== data) begin $display("FAIL rnd_inst i=%0d got=%h exp=%h", i, inst, data); errs++; end else passes++;
      tick();
      checks++; if (rf_wen !== exp_wen) begin $display("FAIL rnd_wen i=%0d got=%b exp=%b", i, rf_wen, exp_wen); errs++; end else passes++;
      tick();
      exp_pc = exp_npc;
      checks++; if (pc !== exp_pc) begin $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, pc, exp_pc); errs++; end else passes++;
      if (errs > 5) break;
    end
    np_force = 1'b0;
`ifdef YSYX_24100005_PERF_CNT_EN
    checks++; if (perf_instret !== 64'd40) $display("FAIL rnd_instret got=%0d exp=40", perf_instret); else passes++;
    checks++; if (perf_cycle !== 64'(cyc - cyc0)) $display("FAIL rnd_cycle got=%0d exp=%0d", perf_cycle, cyc - cyc0); else passes++;
`endif
  endtask

  initial begin
    rst = 1'b0;
    np_force = 1'b0;
    np_val = 32'h0;
    imem_bus.imem_req_ready = 1'b0;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = 32'h0;
    test_reset();
    test_basic();
    test_ready_stall();
    test_ebreak();
    test_timeout();
    test_timeout_edge();
    test_misaligned();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
